// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: round-robin over pipe/LSU/MDU writebacks,
// registered write stage, and a busy scoreboard for long-latency destinations.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_wb_valid,
  input  logic            lsu_wb_valid,
  input  logic            mdu_wb_valid,
  output logic            pipe_wb_ready,
  output logic            lsu_wb_ready,
  output logic            mdu_wb_ready,
  input  logic [4:0]      pipe_wb_rd,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [4:0]      mdu_wb_rd,
  input  logic [XLEN-1:0] pipe_wb_data,
  input  logic [XLEN-1:0] lsu_wb_data,
  input  logic [XLEN-1:0] mdu_wb_data,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hazard_stall,
  output logic            rf_rd_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_rd_datain,
  output logic [31:0]     busy_vec,
  output logic            sb_err
);

  logic [NREQ-1:0]           vld;
  logic [NREQ-1:0][4:0]      req_rd;
  logic [NREQ-1:0][XLEN-1:0] req_data;
  logic [NREQ-1:0]           gnt;
  logic [1:0]                ptr, gidx, idx;
  logic                      xfer;
  logic [4:0]                xfer_rd;
  logic [XLEN-1:0]           xfer_data;
  logic [31:0]               busy, busy_nxt, set_mask, clr_mask;
  logic                      set, clr, set_err, clr_err;
  logic [2:0][4:0]           chk_regs;
  logic [2:0]                hz;

  assign vld      = {mdu_wb_valid, lsu_wb_valid, pipe_wb_valid};
  assign req_rd   = {mdu_wb_rd, lsu_wb_rd, pipe_wb_rd};
  assign req_data = {mdu_wb_data, lsu_wb_data, pipe_wb_data};

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    xfer = 1'b0;
    gidx = ptr;
    idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 2'((int'(ptr) + k) % NREQ);
      if (!xfer && vld[idx]) begin
        xfer = 1'b1;
        gidx = idx;
      end
    end
  end

  assign gnt = xfer ? (NREQ'(1) << gidx) : '0;
  assign {mdu_wb_ready, lsu_wb_ready, pipe_wb_ready} = gnt;

  assign xfer_rd   = req_rd[gidx];
  assign xfer_data = req_data[gidx];

  assign set      = iss_valid & iss_long & (iss_rd != 5'd0);
  assign clr      = xfer & (gidx != 2'd0) & (xfer_rd != 5'd0);
  assign set_mask = set ? (32'd1 << iss_rd) : 32'd0;
  assign clr_mask = clr ? (32'd1 << xfer_rd) : 32'd0;
  // Clear first, then set, so a same-cycle set on the cleared register wins.
  assign busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;
  assign set_err  = set & busy[iss_rd] & ~(clr & (xfer_rd == iss_rd));
  assign clr_err  = clr & ~busy[xfer_rd];
  assign busy_vec = busy;

  // The write-stage term covers the cycle between the busy clear and the RF write.
  assign chk_regs = {chk_rd, chk_rs2, chk_rs1};
  always_comb begin
    hz = '0;
    for (int i = 0; i < 3; i++)
      hz[i] = (chk_regs[i] != 5'd0) &
              (busy[chk_regs[i]] | (rf_rd_en & (rf_rd == chk_regs[i])));
  end
  assign hazard_stall = |hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      rf_rd_en     <= 1'b0;
      rf_rd        <= '0;
      rf_rd_datain <= '0;
      busy         <= '0;
      sb_err       <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      sb_err <= sb_err | set_err | clr_err;
      if (xfer) begin
        ptr          <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        rf_rd_en     <= (xfer_rd != 5'd0);
        rf_rd        <= xfer_rd;
        rf_rd_datain <= xfer_data;
      end else begin
        rf_rd_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: directed checks plus randomized traffic
// against an array/queue reference model; writes are checked by a separate monitor.
module tb_rf_wb_scheduler;

  logic            clk, rst_n;
  logic [2:0]      v;
  logic [2:0][4:0] rdv;
  logic [2:0][31:0] datv;
  logic            pipe_wb_ready, lsu_wb_ready, mdu_wb_ready;
  logic            iss_valid, iss_long;
  logic [4:0]      iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic            hazard_stall, rf_rd_en, sb_err;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_rd_datain, busy_vec;

  rf_wb_scheduler #(.NREQ(3), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(v[0]), .lsu_wb_valid(v[1]), .mdu_wb_valid(v[2]),
    .pipe_wb_ready(pipe_wb_ready), .lsu_wb_ready(lsu_wb_ready), .mdu_wb_ready(mdu_wb_ready),
    .pipe_wb_rd(rdv[0]), .lsu_wb_rd(rdv[1]), .mdu_wb_rd(rdv[2]),
    .pipe_wb_data(datv[0]), .lsu_wb_data(datv[1]), .mdu_wb_data(datv[2]),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard_stall(hazard_stall), .rf_rd_en(rf_rd_en), .rf_rd(rf_rd),
    .rf_rd_datain(rf_rd_datain), .busy_vec(busy_vec), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t q[$];

  int nvec = 0, nerr = 0;
  bit [31:0] m_busy;
  int        m_ptr;
  bit        m_err, m_wen;
  int        m_wrd;
  int        last_g;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Write monitor: every enabled RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_rd_en === 1'b1) begin
      if (q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_write: got rd %0d expected no write at %0t", rf_rd, $time);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_rd", 64'(rf_rd), 64'(e.rd));
        chk("wr_data", 64'(rf_rd_datain), 64'(e.data));
      end
    end
  end

  task automatic idle_inputs();
    v = '0; rdv = '0; datv = '0;
    iss_valid = 0; iss_long = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  // One clock: predict from model, check at negedge, advance model at posedge.
  task automatic cycle();
    int g, hz;
    int regs[3];
    bit clr, set;
    int cr;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int ix;
      ix = (m_ptr + k) % 3;
      if (g < 0 && v[ix]) g = ix;
    end
    regs[0] = chk_rs1; regs[1] = chk_rs2; regs[2] = chk_rd;
    hz = 0;
    foreach (regs[i])
      if (regs[i] != 0 && (m_busy[regs[i]] || (m_wen && m_wrd == regs[i]))) hz = 1;
    if (g >= 0 && rdv[g] != 0) q.push_back('{rd: rdv[g], data: datv[g]});
    @(negedge clk);
    chk("ready", 64'({mdu_wb_ready, lsu_wb_ready, pipe_wb_ready}), (g >= 0) ? 64'(1) << g : 64'(0));
    chk("hazard", 64'(hazard_stall), 64'(hz));
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    chk("sb_err", 64'(sb_err), 64'(m_err));
    @(posedge clk);
    set = iss_valid && iss_long && iss_rd != 0;
    clr = (g > 0) && rdv[g] != 0;
    cr  = (g >= 0) ? int'(rdv[g]) : 0;
    if (set && m_busy[iss_rd] && !(clr && cr == iss_rd)) m_err = 1;
    if (clr && !m_busy[cr]) m_err = 1;
    if (clr) m_busy[cr] = 0;
    if (set) m_busy[iss_rd] = 1;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      m_wen = rdv[g] != 0;
      m_wrd = rdv[g];
    end else m_wen = 0;
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    m_busy = 0; m_ptr = 0; m_err = 0; m_wen = 0; m_wrd = 0;
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    do_reset();

    // Reset mid-write: outputs clear immediately, nothing written afterwards.
    v[0] = 1; rdv[0] = 4; datv[0] = 32'h1234_5678;
    cycle();
    v = '0;
    @(negedge clk); #1;
    chk("pre_reset_en", 64'(rf_rd_en), 64'(1));
    rst_n = 0;
    #1;
    chk("rst_en", 64'(rf_rd_en), 64'(0));
    chk("rst_rd", 64'(rf_rd), 64'(0));
    chk("rst_data", 64'(rf_rd_datain), 64'(0));
    chk("rst_busy", 64'(busy_vec), 64'(0));
    chk("rst_err", 64'(sb_err), 64'(0));
    do_reset();
    repeat (3) cycle();
    chk("post_rst_en", 64'(rf_rd_en), 64'(0));

    // Round robin with all three requesters continuously valid.
    do_reset();
    v = 3'b111; rdv[0] = 1; rdv[1] = 2; rdv[2] = 3;
    datv[0] = 32'hA; datv[1] = 32'hB; datv[2] = 32'hC;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", 64'({mdu_wb_ready, lsu_wb_ready, pipe_wb_ready}), 64'(1) << (k % 3));
      cycle();
      chk("rr_rd", 64'(rf_rd), 64'((k % 3) + 1));
    end
    v = '0;
    cycle();

    // Scoreboard set, LSU clear, and the one-cycle write-stage stall.
    do_reset();
    iss_valid = 1; iss_long = 1; iss_rd = 5;
    cycle();
    iss_valid = 0; iss_long = 0; chk_rs1 = 5;
    v[1] = 1; rdv[1] = 5; datv[1] = 32'hDEAD_BEEF;
    #1 chk("sb_stall_busy", 64'(hazard_stall), 64'(1));
    cycle();
    v = '0;
    #1;
    chk("sb_busy_clr", 64'(busy_vec[5]), 64'(0));
    chk("sb_stall_n1", 64'(hazard_stall), 64'(1));
    chk("sb_en_n1", 64'(rf_rd_en), 64'(1));
    chk("sb_rd_n1", 64'(rf_rd), 64'(5));
    chk("sb_data_n1", 64'(rf_rd_datain), 64'(32'hDEAD_BEEF));
    cycle();
    chk("sb_stall_n2", 64'(hazard_stall), 64'(0));

    // x0 handling.
    do_reset();
    v[2] = 1; rdv[2] = 0; datv[2] = 32'h55;
    #1 chk("x0_ready", 64'(mdu_wb_ready), 64'(1));
    cycle();
    v = '0;
    #1 chk("x0_en", 64'(rf_rd_en), 64'(0));
    iss_valid = 1; iss_long = 1; iss_rd = 3;
    cycle();
    iss_rd = 0;
    cycle();
    iss_valid = 0; iss_long = 0;
    chk("x0_busy", 64'(busy_vec), 64'(32'h8));
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    #1 chk("x0_stall", 64'(hazard_stall), 64'(0));
    cycle();

    // Same-cycle set and clear on x7.
    do_reset();
    iss_valid = 1; iss_long = 1; iss_rd = 7;
    cycle();
    v[2] = 1; rdv[2] = 7; datv[2] = 32'h77;
    cycle();
    v = '0; iss_valid = 0; iss_long = 0;
    chk("sc_busy7", 64'(busy_vec[7]), 64'(1));
    chk("sc_err", 64'(sb_err), 64'(0));
    cycle();

    // Protocol error: clear of a non-busy register, sticky until reset.
    do_reset();
    v[1] = 1; rdv[1] = 9; datv[1] = 32'h99;
    cycle();
    v = '0;
    chk("err_set", 64'(sb_err), 64'(1));
    repeat (3) cycle();
    chk("err_sticky", 64'(sb_err), 64'(1));
    rst_n = 0;
    #1 chk("err_rst", 64'(sb_err), 64'(0));
    do_reset();

    // Randomized traffic: a protocol-clean phase, then an unconstrained one.
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int n = 0; n < (ph == 0 ? 1500 : 400); n++) begin
        for (int i = 0; i < 3; i++) begin
          if (!v[i] && $urandom_range(0, 1) == 1) begin
            int pool[$];
            if (i == 0 || ph == 1) pool.push_back($urandom_range(0, 8));
            else
              for (int r = 1; r <= 8; r++)
                if (m_busy[r] && !(v[3 - i] && rdv[3 - i] == r)) pool.push_back(r);
            if (pool.size() > 0) begin
              v[i] = 1;
              rdv[i] = 5'(pool[$urandom_range(0, pool.size() - 1)]);
              datv[i] = $urandom;
            end
          end
        end
        iss_valid = $urandom_range(0, 9) < 4;
        iss_long  = $urandom_range(0, 1) == 1;
        iss_rd    = 5'($urandom_range(0, 8));
        if (ph == 0) begin
          int fr[$];
          for (int r = 1; r <= 8; r++) if (!m_busy[r]) fr.push_back(r);
          if (fr.size() == 0) iss_long = 0;
          else iss_rd = 5'(fr[$urandom_range(0, fr.size() - 1)]);
        end
        chk_rs1 = 5'($urandom_range(0, 8));
        chk_rs2 = 5'($urandom_range(0, 8));
        chk_rd  = 5'($urandom_range(0, 8));
        cycle();
        if (last_g >= 0) v[last_g] = 0;
      end
      idle_inputs();
      repeat (3) cycle();
      chk("queue_drain", 64'(q.size()), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
